// File: rtl/falcon_gauss_pkg.sv
// Shared constants for the Falcon CDT Gaussian sampler: the gauss_1024_12289
// table, the degree limit, the lane FSM states and the sample-count helper.
package falcon_gauss_pkg;

    localparam int          GAUSS_LEN = 27;
    localparam int unsigned LOGN_MAX  = 10;

    localparam logic [63:0] GAUSS_TAB [0:GAUSS_LEN-1] = '{
        64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
        64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
        64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
        64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
        64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
        64'd586753615614,        64'd77391054539,         64'd9056793210,
        64'd940121950,           64'd86539696,            64'd7062824,
        64'd510971,              64'd32764,               64'd1862,
        64'd94,                  64'd4,                   64'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } gauss_state_e;

    // Number of CDT samples summed per request; out-of-range logn means one sample.
    function automatic logic [9:0] gauss_count(input logic [31:0] logn_v);
        logic [9:0] g_v;
        if (logn_v == 32'd0 || logn_v > 32'(LOGN_MAX)) begin
            g_v = 10'd1;
        end else begin
            g_v = 10'd1 << (32'(LOGN_MAX) - logn_v);
        end
        return g_v;
    endfunction

endpackage

// File: rtl/mkgauss_lanes_cdt.sv
// gauss_cdt_sample: combinational Falcon CDT lookup of one word pair to a
// signed sample in -26..26.
module gauss_cdt_sample
    import falcon_gauss_pkg::*;
(
    input  logic [63:0]       r1,
    input  logic [63:0]       r2,
    output logic signed [5:0] v
);

    logic        neg_s;
    logic        f_s;
    logic        t_s;
    logic [63:0] a_s;
    logic [63:0] b_s;
    logic [63:0] diff_s;
    logic [5:0]  mag_s;

    // Constant-time scan: f blocks all later hits once the first threshold is met.
    always_comb begin
        neg_s  = r1[63];
        a_s    = {1'b0, r1[62:0]};
        b_s    = {1'b0, r2[62:0]};
        diff_s = a_s - GAUSS_TAB[0];
        f_s    = diff_s[63];
        t_s    = 1'b0;
        mag_s  = 6'd0;
        for (int k = 1; k < GAUSS_LEN; k++) begin
            diff_s = b_s - GAUSS_TAB[k];
            t_s    = ~diff_s[63];
            mag_s  = mag_s | (6'(k) & {6{t_s & ~f_s}});
            f_s    = f_s | t_s;
        end
        v = signed'((mag_s ^ {6{neg_s}}) + {5'd0, neg_s});
    end

endmodule

// File: rtl/mkgauss_lanes.sv
// mkgauss_lanes: sums 2^(10-logn) CDT samples per request behind ready/valid.
// Optional MKGAUSS_BACKPRESSURE_EN makes the result wait for val_ready.
module mkgauss_lanes
    import falcon_gauss_pkg::*;
#(
    parameter int VAL_W  = 32,
    parameter int LOGN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [63:0]             r1,
    input  logic [63:0]             r2,
    input  logic [LOGN_W-1:0]       logn,
    output logic                    val_valid,
    input  logic                    val_ready,
    output logic signed [VAL_W-1:0] val,
    output logic                    busy
);

    gauss_state_e             state_r;
    logic [9:0]               g_r;
    logic [9:0]               cnt_r;
    logic signed [14:0]       acc_r;
    logic                     val_valid_r;
    logic signed [VAL_W-1:0]  val_r;
    logic                     busy_r;

    logic signed [5:0]        v_s;
    logic signed [14:0]       v_ext_s;
    logic signed [14:0]       acc_next_s;
    logic [9:0]               g_s;
    logic                     beat_s;
    logic                     out_done_s;

    gauss_cdt_sample u_cdt (
        .r1 (r1),
        .r2 (r2),
        .v  (v_s)
    );

    assign r_ready   = !rst && (state_r != ST_OUT);
    assign beat_s    = r_valid && r_ready;
    assign g_s       = gauss_count(32'(logn));
    assign v_ext_s   = 15'(v_s);
    assign val_valid = val_valid_r;
    assign val       = val_r;
    assign busy      = busy_r;

`ifdef MKGAUSS_BACKPRESSURE_EN
    assign out_done_s = val_ready;
`else
    logic unused_val_ready_s;
    assign unused_val_ready_s = val_ready;
    assign out_done_s         = 1'b1;
`endif

    // The first beat of a request starts a fresh sum; later beats add to it.
    always_comb begin
        acc_next_s = acc_r;
        if (state_r == ST_IDLE) begin
            acc_next_s = v_ext_s;
        end else begin
            acc_next_s = acc_r + v_ext_s;
        end
    end

    // Request FSM with counter, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            g_r         <= 10'd0;
            cnt_r       <= 10'd0;
            acc_r       <= 15'sd0;
            val_valid_r <= 1'b0;
            val_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (beat_s) begin
                        g_r    <= g_s;
                        cnt_r  <= 10'd1;
                        acc_r  <= acc_next_s;
                        busy_r <= 1'b1;
                        if (g_s == 10'd1) begin
                            state_r     <= ST_OUT;
                            val_valid_r <= 1'b1;
                            val_r       <= VAL_W'(acc_next_s);
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (beat_s) begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + 10'd1;
                        if (cnt_r == g_r - 10'd1) begin
                            state_r     <= ST_OUT;
                            val_valid_r <= 1'b1;
                            val_r       <= VAL_W'(acc_next_s);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_done_s) begin
                        state_r     <= ST_IDLE;
                        val_valid_r <= 1'b0;
                        val_r       <= '0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    val_valid_r <= 1'b0;
                    val_r       <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mkgauss_lanes.sv
// Directed self-checking bench for mkgauss_lanes (default or backpressure build).
module tb_mkgauss_lanes;

    localparam logic [63:0] P64 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] N64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] T0  = 64'd1283868770400643928;
    localparam logic [63:0] T1  = 64'd6416574995475331444;
    localparam logic [63:0] T3  = 64'd2353523259288686585;

    logic               clk;
    logic               rst;
    logic               r_valid;
    logic               r_ready;
    logic [63:0]        r1;
    logic [63:0]        r2;
    logic [3:0]         logn;
    logic               val_valid;
    logic               val_ready;
    logic signed [31:0] val;
    logic               busy;

    int checks;
    int errors;

    mkgauss_lanes #(.VAL_W(32), .LOGN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r1        (r1),
        .r2        (r2),
        .logn      (logn),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .val       (val),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-beat request; returns what the output showed on the result cycle.
    task automatic do_single(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ln,
                             output logic vv, output logic signed [31:0] vo);
        r1 = a; r2 = b; logn = ln; r_valid = 1'b1;
        step();
        vv = val_valid;
        vo = val;
        r_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; r_valid = 1'b0; val_ready = 1'b1;
        r1 = 64'd0; r2 = 64'd0; logn = 4'd10;
        step();
        step();
        checks++;
        if (r_ready !== 1'b0 || val_valid !== 1'b0 || val !== 32'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: r_ready=%b val_valid=%b val=%0d busy=%b, want 0 0 0 0",
                     r_ready, val_valid, val, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (r_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: r_ready=%b want 1", r_ready);
        end
    endtask

    task automatic test_cdt_values();
        logic [63:0] t_r1 [0:12] = '{P64, N64, 64'd0, P64, N64, P64, N64,
                                     P64, P64, T0, T0 - 64'd1, 64'h8000_0000_0000_0000, P64};
        logic [63:0] t_r2 [0:12] = '{P64, P64, 64'h0123_4567_89AB_CDEF, T3, T3, 64'd0, 64'd0,
                                     T1, T1 - 64'd1, P64, P64, P64, 64'h8000_0000_0000_0000};
        int          t_exp [0:12] = '{1, -1, 0, 3, -3, 26, -26, 1, 2, 1, 0, 0, 26};
        logic               vv;
        logic signed [31:0] vo;
        for (int i = 0; i < 13; i++) begin
            do_single(t_r1[i], t_r2[i], 4'd10, vv, vo);
            checks++;
            if (vv !== 1'b1 || vo !== t_exp[i]) begin
                errors++;
                $display("FAIL cdt_value[%0d]: val_valid=%b val=%0d, want 1 %0d", i, vv, vo, t_exp[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || val_valid !== 1'b0 || val !== 32'sd0) begin
            errors++;
            $display("FAIL after_out_idle: busy=%b val_valid=%b val=%0d, want 0 0 0", busy, val_valid, val);
        end
    endtask

    task automatic test_logn_clamp();
        logic               vv;
        logic signed [31:0] vo;
        do_single(P64, P64, 4'd0, vv, vo);
        checks++;
        if (vv !== 1'b1 || vo !== 32'sd1) begin
            errors++;
            $display("FAIL logn0_single: val_valid=%b val=%0d, want 1 1", vv, vo);
        end
        do_single(N64, P64, 4'd15, vv, vo);
        checks++;
        if (vv !== 1'b1 || vo !== -32'sd1) begin
            errors++;
            $display("FAIL logn15_single: val_valid=%b val=%0d, want 1 -1", vv, vo);
        end
    endtask

    task automatic test_gap();
        int overlap;
        overlap = 0;
        r1 = P64; r2 = P64; logn = 4'd9; r_valid = 1'b1;
        step();
        if (val_valid && r_ready) overlap++;
        r_valid = 1'b0;
        logn = 4'd10;
        for (int i = 0; i < 3; i++) begin
            step();
            if (val_valid && r_ready) overlap++;
            checks++;
            if (val_valid !== 1'b0 || busy !== 1'b1 || r_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_wait[%0d]: val_valid=%b busy=%b r_ready=%b, want 0 1 1",
                         i, val_valid, busy, r_ready);
            end
        end
        r_valid = 1'b1;
        step();
        if (val_valid && r_ready) overlap++;
        r_valid = 1'b0;
        checks++;
        if (val_valid !== 1'b1 || val !== 32'sd2 || r_ready !== 1'b0) begin
            errors++;
            $display("FAIL gap_result: val_valid=%b val=%0d r_ready=%b, want 1 2 0", val_valid, val, r_ready);
        end
        val_ready = 1'b1;
        step();
        if (val_valid && r_ready) overlap++;
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL gap_overlap: cycles with val_valid&r_ready=%0d, want 0", overlap);
        end
    endtask

    task automatic test_back_to_back();
        int early;
        logic [63:0] m_r1 [0:3] = '{P64, N64, P64, N64};
        logic [63:0] m_r2 [0:3] = '{P64, P64, 64'd0, T3};
        early = 0;
        // First beat in cycle 0; result is expected in cycle 512 (the 513th).
        r1 = P64; r2 = P64; logn = 4'd1; r_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (val_valid) early++;
            step();
        end
        r_valid = 1'b0;
        checks++;
        if (early !== 0 || val_valid !== 1'b1 || val !== 32'sd512) begin
            errors++;
            $display("FAIL b2b_512: early_valid=%0d val_valid=%b val=%0d, want 0 1 512", early, val_valid, val);
        end
        step();
        logn = 4'd8; r_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r1 = m_r1[i]; r2 = m_r2[i];
            step();
        end
        r_valid = 1'b0;
        checks++;
        if (val_valid !== 1'b1 || val !== 32'sd23) begin
            errors++;
            $display("FAIL b2b_mixed_sum: val_valid=%b val=%0d, want 1 23", val_valid, val);
        end
        step();
    endtask

    task automatic test_reset_abort();
        logic               vv;
        logic signed [31:0] vo;
        r1 = P64; r2 = P64; logn = 4'd1; r_valid = 1'b1;
        for (int i = 0; i < 100; i++) step();
        r_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (val_valid !== 1'b0 || busy !== 1'b0 || r_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: val_valid=%b busy=%b r_ready=%b, want 0 0 1", val_valid, busy, r_ready);
        end
        do_single(P64, P64, 4'd10, vv, vo);
        checks++;
        if (vv !== 1'b1 || vo !== 32'sd1) begin
            errors++;
            $display("FAIL abort_next_req: val_valid=%b val=%0d, want 1 1", vv, vo);
        end
    endtask

    task automatic test_output_mode();
        int bad;
        bad = 0;
        r1 = P64; r2 = P64; logn = 4'd10; r_valid = 1'b1; val_ready = 1'b0;
        step();
        r_valid = 1'b0;
`ifdef MKGAUSS_BACKPRESSURE_EN
        for (int i = 0; i < 5; i++) begin
            if (val_valid !== 1'b1 || val !== 32'sd1 || r_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0 || val_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: bad_cycles=%0d val_valid=%b, want 0 1", bad, val_valid);
        end
        val_ready = 1'b1;
        step();
        checks++;
        if (val_valid !== 1'b0 || busy !== 1'b0 || r_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: val_valid=%b busy=%b r_ready=%b, want 0 0 1", val_valid, busy, r_ready);
        end
`else
        if (val_valid !== 1'b1 || val !== 32'sd1) bad++;
        step();
        checks++;
        if (bad !== 0 || val_valid !== 1'b0 || busy !== 1'b0 || r_ready !== 1'b1) begin
            errors++;
            $display("FAIL pulse: bad=%0d val_valid=%b busy=%b r_ready=%b, want 0 0 0 1",
                     bad, val_valid, busy, r_ready);
        end
`endif
        val_ready = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cdt_values();
        test_logn_clamp();
        test_gap();
        test_back_to_back();
        test_reset_abort();
        test_output_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
